// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with press/release debounce.
// Emits one registered ev pulse per keypress with a one-cold {col,row} code.
module keypad_scanner #(
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] kp_col_n,
  output logic [3:0] kp_row_n,
  output logic [3:0] col,
  output logic [3:0] row,
  output logic       ev
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  localparam logic [1:0] S_SCAN    = 2'd0;
  localparam logic [1:0] S_DEB     = 2'd1;
  localparam logic [1:0] S_PRESSED = 2'd2;
  localparam logic [1:0] S_HOLD    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       row_n_q, row_n_d;
  logic [3:0]       cap_col_q, cap_col_d;
  logic [3:0]       col_q, col_d;
  logic [3:0]       row_q, row_d;
  logic             ev_q, ev_d;

  logic       sample;
  logic       valid;
  logic [3:0] row_rot;

  assign sample  = (div_q == DIV_LAST);
  assign valid   = $onehot(~kp_col_n);
  assign row_rot = {row_n_q[0], row_n_q[3:1]};

  always_comb begin
    div_d     = sample ? '0 : div_q + 1'b1;
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_n_d   = row_n_q;
    cap_col_d = cap_col_q;
    col_d     = col_q;
    row_d     = row_q;
    ev_d      = 1'b0;
    unique case (state_q)
      S_SCAN: begin
        if (sample) begin
          if (valid) begin
            cap_col_d = kp_col_n;
            cnt_d     = '0;
            state_d   = S_DEB;
          end else begin
            row_n_d = row_rot;
          end
        end
      end
      S_DEB: begin
        if (sample) begin
          if (kp_col_n == cap_col_q) begin
            if (cnt_q == CNT_LAST) begin
              state_d = S_PRESSED;
              ev_d    = 1'b1;
              col_d   = cap_col_q;
              row_d   = row_n_q;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            state_d = S_SCAN;
            row_n_d = row_rot;
          end
        end
      end
      S_PRESSED: begin
        cnt_d   = '0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        // Any closed contact restarts the release count, even another key.
        if (sample) begin
          if (kp_col_n == 4'hF) begin
            if (cnt_q == CNT_LAST) begin
              state_d = S_SCAN;
              col_d   = 4'hF;
              row_d   = 4'hF;
              row_n_d = row_rot;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d = '0;
          end
        end
      end
      default: state_d = S_SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_SCAN;
      div_q     <= '0;
      cnt_q     <= '0;
      row_n_q   <= 4'b0111;
      cap_col_q <= 4'hF;
      col_q     <= 4'hF;
      row_q     <= 4'hF;
      ev_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      row_n_q   <= row_n_d;
      cap_col_q <= cap_col_d;
      col_q     <= col_d;
      row_q     <= row_d;
      ev_q      <= ev_d;
    end
  end

  assign kp_row_n = row_n_q;
  assign col      = col_q;
  assign row      = row_q;
  assign ev       = ev_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad contact model plus an event scoreboard
// holding the expected {col,row,cycle} of each key event.
module tb_keypad_scanner;

  typedef struct {
    logic [3:0] col;
    logic [3:0] row;
    int         cyc;
  } ev_t;

  logic       clk;
  logic       reset;
  logic [3:0] kp_col_n;
  logic [3:0] kp_row_n;
  logic [3:0] col;
  logic [3:0] row;
  logic       ev;

  logic       key_dn;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic       ghost;
  int         cyc;
  int         n_checks;
  int         n_fail;
  ev_t        sb[$];
  ev_t        obs[$];
  ev_t        e;
  ev_t        o;

  keypad_scanner #(.SCAN_DIV(16), .DEBOUNCE(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .kp_col_n (kp_col_n),
    .kp_row_n (kp_row_n),
    .col      (col),
    .row      (row),
    .ev       (ev)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  // Contact model: the pressed key pulls its column low only while its row is driven.
  always_comb begin
    kp_col_n = 4'hF;
    if (ghost && kp_row_n == 4'b1110)
      kp_col_n = 4'b0011;
    else if (key_dn && kp_row_n == key_row)
      kp_col_n = key_col;
  end

  task automatic run_to(input int n);
    while (cyc < n) begin
      @(negedge clk);
      if (ev) obs.push_back('{col, row, cyc});
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    obs.delete();
  endtask

  task automatic press(input logic [3:0] r, input logic [3:0] c);
    key_row = r;
    key_col = c;
    key_dn  = 1'b1;
  endtask

  task automatic test_reset();
    key_dn = 1'b0;
    ghost  = 1'b0;
    do_reset();
    n_checks++;
    if (kp_row_n !== 4'b0111) begin
      n_fail++;
      $display("FAIL reset_row_n got %b expected 0111", kp_row_n);
    end
    n_checks++;
    if (col !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_col got %b expected 1111", col);
    end
    n_checks++;
    if (row !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_row got %b expected 1111", row);
    end
    n_checks++;
    if (ev !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ev got %b expected 0", ev);
    end
  endtask

  task automatic test_key5();
    press(4'b1011, 4'b1011);
    do_reset();
    sb.push_back('{4'b1011, 4'b1011, 96});
    run_to(20);
    n_checks++;
    if (kp_row_n !== 4'b1011) begin
      n_fail++;
      $display("FAIL key5_row_n20 got %b expected 1011", kp_row_n);
    end
    run_to(96);
    n_checks++;
    if (kp_row_n !== 4'b1011) begin
      n_fail++;
      $display("FAIL key5_row_n96 got %b expected 1011", kp_row_n);
    end
    run_to(150);
    n_checks++;
    if (kp_row_n !== 4'b1011) begin
      n_fail++;
      $display("FAIL key5_row_n150 got %b expected 1011", kp_row_n);
    end
    key_dn = 1'b0;
    run_to(207);
    n_checks++;
    if (col !== 4'b1011 || row !== 4'b1011) begin
      n_fail++;
      $display("FAIL key5_held207 got col=%b row=%b expected 1011/1011", col, row);
    end
    run_to(208);
    n_checks++;
    if (col !== 4'hF || row !== 4'hF) begin
      n_fail++;
      $display("FAIL key5_release got col=%b row=%b expected 1111/1111", col, row);
    end
    run_to(260);
    n_checks++;
    if (obs.size() != sb.size()) begin
      n_fail++;
      $display("FAIL key5_ev_count got %0d expected %0d", obs.size(), sb.size());
    end
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front();
      o = obs.pop_front();
      n_checks++;
      if (o.col !== e.col || o.row !== e.row || o.cyc != e.cyc) begin
        n_fail++;
        $display("FAIL key5_ev got col=%b row=%b cyc=%0d expected col=%b row=%b cyc=%0d",
                 o.col, o.row, o.cyc, e.col, e.row, e.cyc);
      end
    end
  endtask

  task automatic test_bounce();
    key_dn = 1'b0;
    do_reset();
    press(4'b0111, 4'b1101);
    run_to(40);
    key_dn = 1'b0;
    run_to(50);
    n_checks++;
    if (kp_row_n !== 4'b1011) begin
      n_fail++;
      $display("FAIL bounce_rotate got %b expected 1011", kp_row_n);
    end
    sb.push_back('{4'b1101, 4'b0111, 176});
    press(4'b0111, 4'b1101);
    run_to(200);
    key_dn = 1'b0;
    run_to(300);
    n_checks++;
    if (obs.size() != sb.size()) begin
      n_fail++;
      $display("FAIL bounce_ev_count got %0d expected %0d", obs.size(), sb.size());
    end
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front();
      o = obs.pop_front();
      n_checks++;
      if (o.col !== e.col || o.row !== e.row || o.cyc != e.cyc) begin
        n_fail++;
        $display("FAIL bounce_ev got col=%b row=%b cyc=%0d expected col=%b row=%b cyc=%0d",
                 o.col, o.row, o.cyc, e.col, e.row, e.cyc);
      end
    end
  endtask

  task automatic test_ghost();
    key_dn = 1'b0;
    do_reset();
    ghost = 1'b1;
    run_to(20);
    n_checks++;
    if (kp_row_n !== 4'b1011) begin
      n_fail++;
      $display("FAIL ghost_rot20 got %b expected 1011", kp_row_n);
    end
    run_to(70);
    n_checks++;
    if (kp_row_n !== 4'b0111) begin
      n_fail++;
      $display("FAIL ghost_rot70 got %b expected 0111", kp_row_n);
    end
    run_to(500);
    n_checks++;
    if (kp_row_n !== 4'b1110) begin
      n_fail++;
      $display("FAIL ghost_rot500 got %b expected 1110", kp_row_n);
    end
    n_checks++;
    if (col !== 4'hF || row !== 4'hF) begin
      n_fail++;
      $display("FAIL ghost_code got col=%b row=%b expected 1111/1111", col, row);
    end
    ghost = 1'b0;
    n_checks++;
    if (obs.size() != 0) begin
      n_fail++;
      $display("FAIL ghost_ev_count got %0d expected 0", obs.size());
    end
  endtask

  task automatic test_hold_repress();
    key_dn = 1'b0;
    do_reset();
    press(4'b1110, 4'b1101);
    sb.push_back('{4'b1101, 4'b1110, 128});
    run_to(2000);
    key_dn = 1'b0;
    run_to(2063);
    n_checks++;
    if (col !== 4'b1101 || row !== 4'b1110) begin
      n_fail++;
      $display("FAIL hold_held2063 got col=%b row=%b expected 1101/1110", col, row);
    end
    run_to(2064);
    n_checks++;
    if (col !== 4'hF || row !== 4'hF || kp_row_n !== 4'b0111) begin
      n_fail++;
      $display("FAIL hold_release got col=%b row=%b row_n=%b expected 1111/1111/0111",
               col, row, kp_row_n);
    end
    run_to(2080);
    press(4'b1110, 4'b1101);
    sb.push_back('{4'b1101, 4'b1110, 2192});
    run_to(2300);
    key_dn = 1'b0;
    run_to(2400);
    n_checks++;
    if (obs.size() != sb.size()) begin
      n_fail++;
      $display("FAIL hold_ev_count got %0d expected %0d", obs.size(), sb.size());
    end
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front();
      o = obs.pop_front();
      n_checks++;
      if (o.col !== e.col || o.row !== e.row || o.cyc != e.cyc) begin
        n_fail++;
        $display("FAIL hold_ev got col=%b row=%b cyc=%0d expected col=%b row=%b cyc=%0d",
                 o.col, o.row, o.cyc, e.col, e.row, e.cyc);
      end
    end
  endtask

  task automatic test_reset_mid();
    key_dn = 1'b0;
    do_reset();
    press(4'b1110, 4'b1011);
    run_to(100);
    reset  = 1'b1;
    key_dn = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (kp_row_n !== 4'b0111 || col !== 4'hF || row !== 4'hF || ev !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_state got row_n=%b col=%b row=%b ev=%b expected 0111/1111/1111/0",
               kp_row_n, col, row, ev);
    end
    run_to(20);
    n_checks++;
    if (kp_row_n !== 4'b1011) begin
      n_fail++;
      $display("FAIL midrst_restart got %b expected 1011", kp_row_n);
    end
    run_to(300);
    n_checks++;
    if (obs.size() != 0) begin
      n_fail++;
      $display("FAIL midrst_ev_count got %0d expected 0", obs.size());
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    key_dn   = 1'b0;
    key_row  = 4'hF;
    key_col  = 4'hF;
    ghost    = 1'b0;
    test_reset();
    test_key5();
    test_bounce();
    test_ghost();
    test_hold_repress();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
